// File: rtl/stage_mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: func3 access codes,
// FSM state encoding and access-size helpers.
package stage_mem_lsu_pkg;

    // Load func3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Store func3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StResp
    } lsu_state_e;

    // log2 of the access size in bytes, clamped to the bus width.
    function automatic int unsigned lsu_size(input logic [2:0] func3, input int unsigned max_size);
        int unsigned size;
        size = 32'(func3[1:0]);
        return (size > max_size) ? max_size : size;
    endfunction

    // True when the low address bits are not naturally aligned for the access size.
    function automatic logic lsu_misaligned(input logic [2:0] func3, input logic [2:0] off,
                                            input int unsigned max_size);
        int unsigned mask;
        mask = (32'd1 << lsu_size(func3, max_size)) - 32'd1;
        return (32'(off) & mask) != 32'd0;
    endfunction

endpackage

// File: rtl/stage_mem_lsu_if.sv
// Data-memory port: req/gnt/rvalid handshake with byte enables.
interface stage_mem_lsu_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned BE_W = XLEN / 8
) ();
    logic            dm_req;
    logic            dm_we;
    logic [XLEN-1:0] dm_addr;
    logic [XLEN-1:0] dm_wdata;
    logic [BE_W-1:0] dm_be;
    logic            dm_gnt;
    logic            dm_rvalid;
    logic [XLEN-1:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  dm_gnt, dm_rvalid, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output dm_gnt, dm_rvalid, dm_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane alignment: store lane replication and byte enables, load shift and
// sign/zero extension. Purely combinational so other access paths can share it.
// Misaligned offsets are truncated to the natural alignment of the access size.
module lsu_align
    import stage_mem_lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned BE_W = XLEN / 8,
    localparam int unsigned OffW = $clog2(BE_W)
) (
    input  logic [2:0]      func3_i,
    input  logic [OffW-1:0] off_i,
    input  logic [XLEN-1:0] st_data_i,
    input  logic [XLEN-1:0] ld_rdata_i,
    output logic [XLEN-1:0] st_wdata_o,
    output logic [BE_W-1:0] st_be_o,
    output logic [XLEN-1:0] ld_data_o
);
    int unsigned     nbytes;
    int unsigned     lane_mask;
    int unsigned     off;
    int unsigned     nbits;
    logic [XLEN-1:0] ld_shifted;
    logic [XLEN-1:0] ld_sign_vec;
    logic            sign_bit;

    // Access size, lane mask and naturally aligned offset
    always_comb begin
        nbytes    = 32'd1 << lsu_size(func3_i, OffW);
        lane_mask = nbytes - 32'd1;
        off       = 32'(off_i) & ~lane_mask;
        nbits     = 8 * nbytes;
    end

    // Load data moved down to lane 0; sign taken from the top bit of the access
    always_comb begin
        ld_shifted  = ld_rdata_i >> (8 * off);
        ld_sign_vec = ld_shifted >> (nbits - 32'd1);
        sign_bit    = ld_sign_vec[0] & ~func3_i[2];
    end

    for (genvar g = 0; g < BE_W; g++) begin : g_lane
        // Each lane repeats the low access-sized chunk of the store data
        assign st_wdata_o[8*g +: 8] = 8'(st_data_i >> (8 * (32'(g) & lane_mask)));
        assign st_be_o[g]           = (32'(g) >= off) && (32'(g) < off + nbytes);
        assign ld_data_o[8*g +: 8]  = (32'(g) < nbytes) ? ld_shifted[8*g +: 8] : {8{sign_bit}};
    end

endmodule

// File: rtl/stage_mem_lsu.sv
// MEM-stage load/store unit. Issues one data-memory access per memory
// instruction over a req/gnt/rvalid port and stalls the pipeline until it
// completes. Optional build macro LSU_MISALIGN_TRAP_EN turns misaligned
// accesses into a one-cycle me_misalign pulse instead of truncating them.
module stage_mem_lsu
    import stage_mem_lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned BE_W = XLEN / 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            me_valid,
    input  logic            me_mem_read,
    input  logic            me_mem_write,
    input  logic [2:0]      me_func3_code,
    input  logic [XLEN-1:0] me_alu_o,
    input  logic [XLEN-1:0] me_regs_data2,
    input  logic            forward_data,
    input  logic [XLEN-1:0] w_regs_data,
    output logic [XLEN-1:0] me_mem_data,
    output logic            me_done,
    output logic            me_stall,
    output logic            me_misalign,
    stage_mem_lsu_if.master dm
);
    localparam int unsigned OffW = $clog2(BE_W);

    lsu_state_e      state_q, state_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0] be_q, be_d;
    logic [2:0]      func3_q, func3_d;
    logic [OffW-1:0] off_q, off_d;
    logic [XLEN-1:0] mem_data_q, mem_data_d;
    logic            done_q, done_d;
    logic            stall;

    logic            mem_op;
    logic            is_store;
    logic            trap;
    logic [2:0]      al_func3;
    logic [OffW-1:0] al_off;
    logic [XLEN-1:0] st_data;
    logic [XLEN-1:0] al_wdata;
    logic [BE_W-1:0] al_be;
    logic [XLEN-1:0] al_ld;

    assign mem_op   = me_valid & (me_mem_read | me_mem_write);
    // A read wins when both read and write are flagged
    assign is_store = me_mem_write & ~me_mem_read;
    assign st_data  = forward_data ? w_regs_data : me_regs_data2;

    // Idle aligns the incoming instruction; later states align the latched access
    assign al_func3 = (state_q == StIdle) ? me_func3_code : func3_q;
    assign al_off   = (state_q == StIdle) ? me_alu_o[OffW-1:0] : off_q;

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    assign trap        = lsu_misaligned(me_func3_code, 3'(me_alu_o[OffW-1:0]), OffW);
    assign misalign_d  = (state_q == StIdle) & mem_op & trap;
    assign me_misalign = misalign_q;
`else
    assign trap        = 1'b0;
    assign me_misalign = 1'b0;
`endif

    lsu_align #(
        .XLEN (XLEN),
        .BE_W (BE_W)
    ) u_align (
        .func3_i    (al_func3),
        .off_i      (al_off),
        .st_data_i  (st_data),
        .ld_rdata_i (dm.dm_rdata),
        .st_wdata_o (al_wdata),
        .st_be_o    (al_be),
        .ld_data_o  (al_ld)
    );

    // Next-state, bus and stall logic of the access FSM
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        func3_d    = func3_q;
        off_d      = off_q;
        mem_data_d = mem_data_q;
        done_d     = 1'b0;
        stall      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_op && !trap) begin
                    stall   = 1'b1;
                    state_d = StReq;
                    req_d   = 1'b1;
                    we_d    = is_store;
                    addr_d  = {me_alu_o[XLEN-1:OffW], {OffW{1'b0}}};
                    wdata_d = al_wdata;
                    be_d    = al_be;
                    func3_d = me_func3_code;
                    off_d   = me_alu_o[OffW-1:0];
                end
            end
            StReq: begin
                stall = 1'b1;
                if (dm.dm_gnt) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        state_d = StResp;
                        done_d  = 1'b1;
                    end else if (dm.dm_rvalid) begin
                        // Zero-latency read data arriving with the grant
                        mem_data_d = al_ld;
                        state_d    = StResp;
                        done_d     = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                stall = 1'b1;
                if (dm.dm_rvalid) begin
                    mem_data_d = al_ld;
                    state_d    = StResp;
                    done_d     = 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (rst) begin
            stall = 1'b0;
        end
    end

    // State and registered outputs; reset abandons any outstanding access
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            func3_q    <= 3'b000;
            off_q      <= '0;
            mem_data_q <= '0;
            done_q     <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            func3_q    <= func3_d;
            off_q      <= off_d;
            mem_data_q <= mem_data_d;
            done_q     <= done_d;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign dm.dm_req   = req_q;
    assign dm.dm_we    = we_q;
    assign dm.dm_addr  = addr_q;
    assign dm.dm_wdata = wdata_q;
    assign dm.dm_be    = be_q;
    assign me_mem_data = mem_data_q;
    assign me_done     = done_q;
    assign me_stall    = stall;

endmodule
